mc_controller: RTL and testbench

Multicycle control unit for the processor datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer side of the ALU's 3-bit function code. It drives every datapath mux select and write enable, and consumes the ALU zero flag for branch resolution. It sits beside the datapath in the processor top and is the only block that drives ALU `F`.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_controller_alu_decoder.sv | 34 +++
 rtl/mc_controller.sv | 148 ++++++++++++++
 tb/tb_mc_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Holds the state enum, opcode/funct constants, ALU codes and mux encodings.
// Imported by the controller top and the ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU function decoder: maps (aluop, funct) to the 3-bit ALU code F.
// Purely combinational, zero latency; no flow control.
// bad_funct flags an unsupported funct, only meaningful when aluop selects funct.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  // Fixed add/sub for address and branch math, funct lookup for R-type
  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_MUL:  alu_control = ALU_MUL;
          default: bad_funct   = 1'b1;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Outputs are combinational decodes of the state register; one state per cycle.
// Memory handshake: FETCH, MEMRD and MEMWR hold until mem_ready is seen high.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alu_control,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op
);

  state_t     state;
  state_t     next_state;
  state_t     cur;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       ir_en;
  logic       mw_en;
  logic       rw_en;
  logic       bad_op;
  logic       bad_funct;

  // During reset the outputs decode as FETCH so the datapath muxes sit at a known point
  assign cur = reset ? FETCH : state;

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Per-state output decode and next-state selection
  always_comb begin
    next_state = FETCH;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mw_en      = 1'b0;
    rw_en      = 1'b0;
    bad_op     = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb    = SRCB_FOUR;
        ir_en      = mem_ready;
        pcwrite    = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default: begin
            next_state = FETCH;
            bad_op     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw_en    = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mw_en      = 1'b1;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = bad_funct ? FETCH : ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        rw_en  = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        rw_en = 1'b1;
      end
      JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control),
    .bad_funct   (bad_funct)
  );

  // No architectural write may escape while reset is asserted
  assign irwrite    = ir_en & ~reset;
  assign memwrite   = mw_en & ~reset;
  assign regwrite   = rw_en & ~reset;
  assign pcen       = (pcwrite | (branch & zero)) & ~reset;
  assign illegal_op = (bad_op | bad_funct) & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle vector table plus reset and stall sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alu_control;
  logic [1:0] pcsrc;
  logic       pcen, illegal_op;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .alu_control (alu_control),
    .pcsrc       (pcsrc),
    .pcen        (pcen),
    .illegal_op  (illegal_op)
  );

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca}_alusrcb_alu_pcsrc_pcen_illegal
  logic [16:0] outs;
  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, alu_control, pcsrc, pcen, illegal_op};

  localparam logic [16:0] E_RST    = 17'b0000000_01_010_00_0_0;
  localparam logic [16:0] E_FETCH  = 17'b0010000_01_010_00_1_0;
  localparam logic [16:0] E_FWAIT  = 17'b0000000_01_010_00_0_0;
  localparam logic [16:0] E_DEC    = 17'b0000000_11_010_00_0_0;
  localparam logic [16:0] E_DECILL = 17'b0000000_11_010_00_0_1;
  localparam logic [16:0] E_MADR   = 17'b0000001_10_010_00_0_0;
  localparam logic [16:0] E_MRD    = 17'b1000000_00_010_00_0_0;
  localparam logic [16:0] E_MWB    = 17'b0000110_00_010_00_0_0;
  localparam logic [16:0] E_MWR    = 17'b1100000_00_010_00_0_0;
  localparam logic [16:0] E_EXADD  = 17'b0000001_00_010_00_0_0;
  localparam logic [16:0] E_EXSUB  = 17'b0000001_00_110_00_0_0;
  localparam logic [16:0] E_EXAND  = 17'b0000001_00_000_00_0_0;
  localparam logic [16:0] E_EXOR   = 17'b0000001_00_001_00_0_0;
  localparam logic [16:0] E_EXSLT  = 17'b0000001_00_111_00_0_0;
  localparam logic [16:0] E_EXMUL  = 17'b0000001_00_011_00_0_0;
  localparam logic [16:0] E_EXILL  = 17'b0000001_00_010_00_0_1;
  localparam logic [16:0] E_ALUWB  = 17'b0001010_00_010_00_0_0;
  localparam logic [16:0] E_BRT    = 17'b0000001_00_110_01_1_0;
  localparam logic [16:0] E_BRN    = 17'b0000001_00_110_01_0_0;
  localparam logic [16:0] E_AEX    = 17'b0000001_10_010_00_0_0;
  localparam logic [16:0] E_AWB    = 17'b0000010_00_010_00_0_0;
  localparam logic [16:0] E_JMP    = 17'b0000000_00_010_10_1_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add_vec(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic m, input logic [16:0] e,
                         input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.mr = m; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m);
    @(negedge clk);
    reset = r; op = o; funct = f; zero = z; mem_ready = m;
    #1;
  endtask

  initial begin
    int cycles, iord_cnt, stalls;
    bit done;
    reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;

    // One row per clock cycle, consecutive rows form complete instructions
    add_vec(1, 6'h00, 6'h00, 0, 1, E_RST,    "reset_a");
    add_vec(1, 6'h00, 6'h00, 0, 1, E_RST,    "reset_b");
    add_vec(0, 6'h00, 6'h22, 0, 1, E_FETCH,  "sub_fetch");
    add_vec(0, 6'h00, 6'h22, 0, 1, E_DEC,    "sub_decode");
    add_vec(0, 6'h00, 6'h22, 0, 1, E_EXSUB,  "sub_exec");
    add_vec(0, 6'h00, 6'h22, 0, 1, E_ALUWB,  "sub_aluwb");
    add_vec(0, 6'h00, 6'h18, 0, 0, E_FWAIT,  "mul_fetch_stall");
    add_vec(0, 6'h00, 6'h18, 0, 1, E_FETCH,  "mul_fetch");
    add_vec(0, 6'h00, 6'h18, 0, 1, E_DEC,    "mul_decode");
    add_vec(0, 6'h00, 6'h18, 0, 1, E_EXMUL,  "mul_exec");
    add_vec(0, 6'h00, 6'h18, 0, 1, E_ALUWB,  "mul_aluwb");
    add_vec(0, 6'h00, 6'h20, 0, 1, E_FETCH,  "add_fetch");
    add_vec(0, 6'h00, 6'h20, 0, 1, E_DEC,    "add_decode");
    add_vec(0, 6'h00, 6'h20, 0, 1, E_EXADD,  "add_exec");
    add_vec(0, 6'h00, 6'h20, 0, 1, E_ALUWB,  "add_aluwb");
    add_vec(0, 6'h00, 6'h24, 0, 1, E_FETCH,  "and_fetch");
    add_vec(0, 6'h00, 6'h24, 0, 1, E_DEC,    "and_decode");
    add_vec(0, 6'h00, 6'h24, 0, 1, E_EXAND,  "and_exec");
    add_vec(0, 6'h00, 6'h24, 0, 1, E_ALUWB,  "and_aluwb");
    add_vec(0, 6'h00, 6'h25, 0, 1, E_FETCH,  "or_fetch");
    add_vec(0, 6'h00, 6'h25, 0, 1, E_DEC,    "or_decode");
    add_vec(0, 6'h00, 6'h25, 0, 1, E_EXOR,   "or_exec");
    add_vec(0, 6'h00, 6'h25, 0, 1, E_ALUWB,  "or_aluwb");
    add_vec(0, 6'h00, 6'h2a, 0, 1, E_FETCH,  "slt_fetch");
    add_vec(0, 6'h00, 6'h2a, 0, 1, E_DEC,    "slt_decode");
    add_vec(0, 6'h00, 6'h2a, 0, 1, E_EXSLT,  "slt_exec");
    add_vec(0, 6'h00, 6'h2a, 0, 1, E_ALUWB,  "slt_aluwb");
    add_vec(0, 6'h00, 6'h3f, 0, 1, E_FETCH,  "badfn_fetch");
    add_vec(0, 6'h00, 6'h3f, 0, 1, E_DEC,    "badfn_decode");
    add_vec(0, 6'h00, 6'h3f, 0, 1, E_EXILL,  "badfn_exec");
    add_vec(0, 6'h04, 6'h00, 1, 1, E_FETCH,  "beqt_fetch_after_badfn");
    add_vec(0, 6'h04, 6'h00, 1, 1, E_DEC,    "beqt_decode");
    add_vec(0, 6'h04, 6'h00, 1, 1, E_BRT,    "beqt_branch");
    add_vec(0, 6'h04, 6'h00, 0, 1, E_FETCH,  "beqn_fetch");
    add_vec(0, 6'h04, 6'h00, 0, 1, E_DEC,    "beqn_decode");
    add_vec(0, 6'h04, 6'h00, 0, 1, E_BRN,    "beqn_branch");
    add_vec(0, 6'h3f, 6'h00, 0, 1, E_FETCH,  "badop_fetch");
    add_vec(0, 6'h3f, 6'h00, 0, 1, E_DECILL, "badop_decode");
    add_vec(0, 6'h02, 6'h00, 0, 1, E_FETCH,  "j_fetch_after_badop");
    add_vec(0, 6'h02, 6'h00, 0, 1, E_DEC,    "j_decode");
    add_vec(0, 6'h02, 6'h00, 0, 1, E_JMP,    "j_jump");
    add_vec(0, 6'h08, 6'h00, 0, 1, E_FETCH,  "addi_fetch");
    add_vec(0, 6'h08, 6'h00, 0, 1, E_DEC,    "addi_decode");
    add_vec(0, 6'h08, 6'h00, 0, 1, E_AEX,    "addi_exec");
    add_vec(0, 6'h08, 6'h00, 0, 1, E_AWB,    "addi_wb");
    add_vec(0, 6'h2b, 6'h00, 0, 1, E_FETCH,  "sw_fetch");
    add_vec(0, 6'h2b, 6'h00, 0, 1, E_DEC,    "sw_decode");
    add_vec(0, 6'h2b, 6'h00, 0, 1, E_MADR,   "sw_memadr");
    add_vec(0, 6'h2b, 6'h00, 0, 1, E_MWR,    "sw_memwr");
    add_vec(0, 6'h23, 6'h00, 0, 1, E_FETCH,  "lw_fetch");
    add_vec(0, 6'h23, 6'h00, 0, 1, E_DEC,    "lw_decode");
    add_vec(0, 6'h23, 6'h00, 0, 1, E_MADR,   "lw_memadr");
    add_vec(0, 6'h23, 6'h00, 0, 1, E_MRD,    "lw_memrd");
    add_vec(0, 6'h23, 6'h00, 0, 1, E_MWB,    "lw_memwb");
    add_vec(0, 6'h00, 6'h20, 0, 1, E_FETCH,  "final_fetch");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
      check(vecs[i].name, {15'd0, outs}, {15'd0, vecs[i].exp});
    end

    // sw stalled in MEMWR, then reset held 3 cycles in the middle of the write
    drive(0, 6'h2b, 6'h00, 0, 1);   // DECODE (state reached from final_fetch)
    check("rstmw_decode", {15'd0, outs}, {15'd0, E_DEC});
    drive(0, 6'h2b, 6'h00, 0, 1);   // MEMADR
    drive(0, 6'h2b, 6'h00, 0, 0);
    check("rstmw_memwr_stall1", {31'd0, memwrite}, 32'd1);
    drive(0, 6'h2b, 6'h00, 0, 0);
    check("rstmw_memwr_stall2", {31'd0, memwrite}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 6'h2b, 6'h00, 1, 1);
      check($sformatf("rstmw_memwrite_%0d", k), {31'd0, memwrite}, 32'd0);
      check($sformatf("rstmw_outs_%0d", k), {15'd0, outs}, {15'd0, E_RST});
    end
    drive(0, 6'h2b, 6'h00, 0, 1);
    check("rstmw_release_irwrite", {31'd0, irwrite}, 32'd1);
    check("rstmw_release_pcen", {31'd0, pcen}, 32'd1);
    check("rstmw_release_outs", {15'd0, outs}, {15'd0, E_FETCH});

    // lw with mem_ready low for the first two MEMRD cycles: 7 cycles, iord held 3
    drive(1, 6'h23, 6'h00, 0, 1);
    cycles = 0; iord_cnt = 0; stalls = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      reset = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0;
      if (iord && !memwrite && stalls < 2) begin
        mem_ready = 1'b0;
        stalls++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cycles++;
      if (iord) iord_cnt++;
      if (memtoreg && regwrite) done = 1'b1;
    end
    check("lwstall_reached_memwb", {31'd0, done}, 32'd1);
    check("lwstall_cycles", cycles, 32'd7);
    check("lwstall_iord_cycles", iord_cnt, 32'd3);
    drive(0, 6'h23, 6'h00, 0, 1);
    check("lwstall_back_to_fetch", {15'd0, outs}, {15'd0, E_FETCH});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
